// File: rtl/parallel_addsub_pipe.sv
// N-lane signed add/subtract pipeline with valid/ready flow control and per-lane overflow flags.
// Define PARALLEL_ADDSUB_PIPE_SAT_EN to saturate overflowing lanes; otherwise they wrap.
`timescale 1ns/1ps
module parallel_addsub_pipe #(
  parameter int unsigned N   = 4,
  parameter int unsigned W   = 8,
  parameter int unsigned LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] a [N],
  input  logic signed [W-1:0] b [N],
  input  logic [N-1:0]        sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] sum [N],
  output logic [N-1:0]        ovf,
  output logic [N-1:0]        ovf_sticky,
  input  logic                clr_sticky
);

`ifdef PARALLEL_ADDSUB_PIPE_SAT_EN
  localparam logic signed [W-1:0] SatMax = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SatMin = {1'b1, {(W-1){1'b0}}};
`endif

  logic                advance;
  logic                out_xfer;
  logic signed [W:0]   exact [N];
  logic signed [W-1:0] res [N];
  logic [N-1:0]        res_ovf;

  logic [LAT-1:0]      vld_q;
  logic signed [W-1:0] sum_q [LAT][N];
  logic [N-1:0]        ovf_q [LAT];
  logic [N-1:0]        sticky_q;
  logic [N-1:0]        sticky_d;

  // The whole pipe moves together; a stalled output freezes every stage.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !rst;
  assign out_xfer = out_valid && out_ready;

  // Operands are sign-extended to W+1 bits so the result is exact, even for a - (-2^(W-1)).
  always_comb begin
    for (int i = 0; i < N; i++) begin
      exact[i]   = '0;
      res[i]     = '0;
      res_ovf[i] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (sub[i]) begin
        exact[i] = {a[i][W-1], a[i]} - {b[i][W-1], b[i]};
      end else begin
        exact[i] = {a[i][W-1], a[i]} + {b[i][W-1], b[i]};
      end
      res_ovf[i] = exact[i][W] ^ exact[i][W-1];
`ifdef PARALLEL_ADDSUB_PIPE_SAT_EN
      if (res_ovf[i]) begin
        res[i] = exact[i][W] ? SatMin : SatMax;
      end else begin
        res[i] = exact[i][W-1:0];
      end
`else
      res[i] = exact[i][W-1:0];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s < LAT; s++) begin
        ovf_q[s] <= '0;
        for (int i = 0; i < N; i++) begin
          sum_q[s][i] <= '0;
        end
      end
    end else if (advance) begin
      vld_q[0] <= in_valid;
      sum_q[0] <= res;
      ovf_q[0] <= res_ovf;
      for (int s = 1; s < LAT; s++) begin
        vld_q[s] <= vld_q[s-1];
        sum_q[s] <= sum_q[s-1];
        ovf_q[s] <= ovf_q[s-1];
      end
    end
  end

  // A setting transfer takes priority over a coincident clear.
  always_comb begin
    sticky_d = clr_sticky ? '0 : sticky_q;
    if (out_xfer) begin
      sticky_d = sticky_d | ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign out_valid  = vld_q[LAT-1];
  assign sum        = sum_q[LAT-1];
  assign ovf        = ovf_q[LAT-1];
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_parallel_addsub_pipe.sv
// Directed and randomized checks of parallel_addsub_pipe (N=4, W=8, LAT=2) in either build.
`timescale 1ns/1ps
module tb_parallel_addsub_pipe;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int LAT = 2;

`ifdef PARALLEL_ADDSUB_PIPE_SAT_EN
  localparam int ExpPosOvf = 127;
  localparam int ExpNegOvf = -128;
`else
  localparam int ExpPosOvf = -128;
  localparam int ExpNegOvf = 127;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] a [N];
  logic signed [W-1:0] b [N];
  logic [N-1:0]        sub;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic signed [W-1:0] sum [N];
  logic [N-1:0]        ovf;
  logic [N-1:0]        ovf_sticky;
  logic                clr_sticky = 1'b0;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  parallel_addsub_pipe #(.N(N), .W(W), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .sub        (sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .ovf        (ovf),
    .ovf_sticky (ovf_sticky),
    .clr_sticky (clr_sticky)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ops();
    for (int i = 0; i < N; i++) begin
      a[i] = '0;
      b[i] = '0;
    end
    sub = '0;
  endtask

  task automatic set_lane(input int i, input int av, input int bv, input bit s);
    a[i]   = W'(av);
    b[i]   = W'(bv);
    sub[i] = s;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    repeat (LAT + 1) tick();
  endtask

  // Exact integer reference for one lane: {overflow, result}.
  function automatic logic [W:0] model_lane(input int av, input int bv, input bit s);
    int ex;
    int r;
    bit ov;
    ex = s ? av - bv : av + bv;
    ov = (ex > 127) || (ex < -128);
`ifdef PARALLEL_ADDSUB_PIPE_SAT_EN
    r = ov ? ((ex > 0) ? 127 : -128) : ex;
`else
    r = ex;
`endif
    return {ov, r[W-1:0]};
  endfunction

  task automatic test_reset();
    clear_ops();
    repeat (2) tick();
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++;
    if (ovf !== 4'b0000) begin fails++; $display("FAIL reset_ovf: got %b expected 0000", ovf); end
    checks++;
    if (ovf_sticky !== 4'b0000) begin fails++; $display("FAIL reset_sticky: got %b expected 0000", ovf_sticky); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (sum[i] !== W'(0)) begin fails++; $display("FAIL reset_sum%0d: got %0d expected 0", i, sum[i]); end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_add();
    clear_ops();
    set_lane(0, 100, 27, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL add_latency_early: got %b expected 0", out_valid); end
    tick();
    checks++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL add_latency: got %b expected 1", out_valid); end
    checks++;
    if (sum[0] !== W'(127)) begin fails++; $display("FAIL add_127: got %0d expected 127", sum[0]); end
    checks++;
    if (ovf !== 4'b0000) begin fails++; $display("FAIL add_127_ovf: got %b expected 0000", ovf); end
    set_lane(0, 100, 28, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL add_ovf_valid: got %b expected 1", out_valid); end
    checks++;
    if (sum[0] !== W'(ExpPosOvf)) begin
      fails++; $display("FAIL add_ovf_sum: got %0d expected %0d", sum[0], ExpPosOvf);
    end
    checks++;
    if (ovf !== 4'b0001) begin fails++; $display("FAIL add_ovf_flag: got %b expected 0001", ovf); end
    drain();
  endtask

  task automatic test_sub();
    clear_ops();
    set_lane(0, 10, 3, 1'b1);
    set_lane(1, -128, 1, 1'b1);
    set_lane(2, -5, -128, 1'b1);
    set_lane(3, 50, 20, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (sum[0] !== W'(7)) begin fails++; $display("FAIL sub_lane0: got %0d expected 7", sum[0]); end
    checks++;
    if (sum[1] !== W'(ExpNegOvf)) begin
      fails++; $display("FAIL sub_lane1: got %0d expected %0d", sum[1], ExpNegOvf);
    end
    checks++;
    if (sum[2] !== W'(123)) begin fails++; $display("FAIL sub_lane2: got %0d expected 123", sum[2]); end
    checks++;
    if (sum[3] !== W'(70)) begin fails++; $display("FAIL sub_lane3_add: got %0d expected 70", sum[3]); end
    checks++;
    if (ovf !== 4'b0010) begin fails++; $display("FAIL sub_ovf: got %b expected 0010", ovf); end
    drain();
  endtask

  task automatic test_sticky();
    checks++;
    if (ovf_sticky !== 4'b0011) begin fails++; $display("FAIL sticky_accum: got %b expected 0011", ovf_sticky); end
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    checks++;
    if (ovf_sticky !== 4'b0000) begin fails++; $display("FAIL sticky_clr: got %b expected 0000", ovf_sticky); end
    clear_ops();
    set_lane(3, 127, 1, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (ovf_sticky !== 4'b0000) begin fails++; $display("FAIL sticky_early: got %b expected 0000", ovf_sticky); end
    tick();
    checks++;
    if (ovf_sticky !== 4'b1000) begin fails++; $display("FAIL sticky_set: got %b expected 1000", ovf_sticky); end
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    checks++;
    if (ovf_sticky !== 4'b0000) begin fails++; $display("FAIL sticky_clr2: got %b expected 0000", ovf_sticky); end
    set_lane(3, -128, 1, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    checks++;
    if (ovf_sticky !== 4'b1000) begin fails++; $display("FAIL sticky_set_wins: got %b expected 1000", ovf_sticky); end
    drain();
  endtask

  task automatic test_back_to_back();
    int exp0 [6] = '{11, 22, 33, 44, 55, 66};
    int exp1 [6] = '{-19, -18, -17, -16, -15, -14};
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int stall_left = -1;
    logic signed [W-1:0] held = '0;
    clear_ops();
    while (got < 6 && cyc < 60) begin
      in_valid = (sent < 6);
      if (sent < 6) begin
        set_lane(0, 10 * (sent + 1), sent + 1, 1'b0);
        set_lane(1, sent + 1, 20, 1'b1);
      end
      if (out_valid && stall_left < 0) stall_left = 3;
      out_ready = !(stall_left > 0);
      #1;
      if (stall_left > 0) begin
        checks++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_stall_ready: got %b expected 0", in_ready); end
        if (stall_left < 3) begin
          checks++;
          if (sum[0] !== held) begin fails++; $display("FAIL b2b_hold: got %0d expected %0d", sum[0], held); end
        end
        held = sum[0];
        stall_left--;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sum[0] !== W'(exp0[got]) || sum[1] !== W'(exp1[got])) begin
          fails++;
          $display("FAIL b2b_beat%0d: got %0d/%0d expected %0d/%0d", got, sum[0], sum[1],
                   exp0[got], exp1[got]);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got != 6) begin fails++; $display("FAIL b2b_count: got %0d expected 6", got); end
    repeat (2) begin
      checks++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_extra: got %b expected 0", out_valid); end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    clear_ops();
    set_lane(0, 1, 1, 1'b0);
    set_lane(2, 127, 127, 1'b0);
    in_valid = 1'b1;
    tick();
    set_lane(0, 2, 2, 1'b0);
    set_lane(2, 0, 0, 1'b0);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_inflight: got %b expected 1", out_valid); end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL mid_in_ready: got %b expected 0", in_ready); end
    checks++;
    if (sum[0] !== W'(0) || sum[2] !== W'(0)) begin
      fails++; $display("FAIL mid_sum: got %0d/%0d expected 0/0", sum[0], sum[2]);
    end
    checks++;
    if (ovf_sticky !== 4'b0000) begin fails++; $display("FAIL mid_sticky: got %b expected 0000", ovf_sticky); end
    tick();
    rst = 1'b0;
    repeat (4) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_stale: got %b expected 0", out_valid); end
    end
    set_lane(0, 5, 5, 1'b0);
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_ready_after: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_next_early: got %b expected 0", out_valid); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || sum[0] !== W'(10)) begin
      fails++; $display("FAIL mid_next_beat: got valid %b sum %0d expected 1/10", out_valid, sum[0]);
    end
    drain();
  endtask

  task automatic test_random();
    logic [N*W+N-1:0] q [$];
    logic [N*W+N-1:0] exp_b;
    logic [N*W+N-1:0] got_b;
    logic [W:0]       m;
    int acc = 0;
    int cyc = 0;
    while ((acc < 1000 || q.size() != 0) && cyc < 20000) begin
      in_valid = (acc < 1000) && ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        a[i]   = W'($urandom);
        b[i]   = W'($urandom);
        sub[i] = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (out_valid && out_ready) begin
        for (int i = 0; i < N; i++) got_b[i*W +: W] = sum[i];
        got_b[N*W +: N] = ovf;
        checks++;
        if (q.size() == 0) begin
          fails++; $display("FAIL rand_unexpected: got %h expected no beat", got_b);
        end else begin
          exp_b = q.pop_front();
          if (got_b !== exp_b) begin
            fails++; $display("FAIL rand_beat: got %h expected %h", got_b, exp_b);
          end
        end
      end
      if (in_valid && in_ready) begin
        for (int i = 0; i < N; i++) begin
          m = model_lane(int'(a[i]), int'(b[i]), sub[i]);
          exp_b[i*W +: W] = m[W-1:0];
          exp_b[N*W + i]  = m[W];
        end
        q.push_back(exp_b);
        acc++;
      end
      tick();
      cyc++;
    end
    checks++;
    if (acc != 1000 || q.size() != 0) begin
      fails++; $display("FAIL rand_complete: got %0d accepted %0d pending expected 1000/0", acc, q.size());
    end
    out_ready = 1'b1;
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_ops();
    test_reset();
    test_add();
    test_sub();
    test_sticky();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/parallel_addsub_pipe.md
PARALLEL_ADDSUB_PIPE -- requirements
Module: parallel_addsub_pipe

Interface
REQ-001 Parameter N, default 4, number of independent lanes (1..16).
REQ-002 Parameter W, default 8, signed lane width in bits (2..32).
REQ-003 Parameter LAT, default 2, pipeline depth in register stages (1..4).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  input beat present.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 a  input  N x W signed, unpacked array [N]  first operands.
REQ-009 b  input  N x W signed, unpacked array [N]  second operands.
REQ-010 sub  input  N  per-lane op: 0 = a+b, 1 = a-b.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 sum  output  N x W signed, unpacked array [N]  per-lane results.
REQ-014 ovf  output  N  per-lane overflow flag, aligned with sum.
REQ-015 ovf_sticky  output  N  per-lane accumulated overflow status.
REQ-016 clr_sticky  input  1  synchronous clear of ovf_sticky.

Function
REQ-017 Transfer in: in_valid && in_ready at rising edge; transfer out: out_valid && out_ready at rising edge.
REQ-018 Pipeline advances when advance = !out_valid || out_ready; whole pipe stalls otherwise; in_ready = advance && !rst.
REQ-019 Beats are never dropped, duplicated or reordered; bubbles (in_valid low on advance) propagate as invalid stages.
REQ-020 With no stall, a beat accepted at edge k has out_valid high after edge k+LAT-1, i.e. LAT cycles from presentation to result; full throughput of one beat per cycle.
REQ-021 Each lane computes a+b or a-b at W+1 bits exactly, including b = -2^(W-1) under subtraction.
REQ-022 ovf[i] = 1 when the exact W+1-bit result lies outside [-2^(W-1), 2^(W-1)-1].
REQ-023 sum and ovf shall hold stable while out_valid && !out_ready.
REQ-024 ovf_sticky[i] sets on each output transfer whose ovf[i] = 1; cleared by clr_sticky at the same edge otherwise.
REQ-025 clr_sticky coincident with a setting transfer: set wins, bit ends 1.
REQ-026 Lanes are fully independent; sub may differ per lane within one beat.

Reset
REQ-027 While rst high: out_valid 0, in_ready 0, sum all 0, ovf 0, ovf_sticky 0, all stage valids 0.
REQ-028 rst asserted mid-operation discards every in-flight beat immediately (asynchronously); no discarded beat appears after release.
REQ-029 First edge after rst release with in_valid high accepts a beat (in_ready = 1).

Configuration
REQ-030 Macro PARALLEL_ADDSUB_PIPE_SAT_EN selects overflow handling.
REQ-031 Defined: overflowing lanes clamp to 2^(W-1)-1 (positive overflow) or -2^(W-1) (negative overflow).
REQ-032 Undefined: overflowing lanes wrap, sum = low W bits of exact result.
REQ-033 ovf, ovf_sticky, latency and handshake identical in both builds.

Verification (N=4, W=8, LAT=2, out_ready=1 unless stated)
REQ-034 Lane0 add 100+27 -> sum 127, ovf 0; lane0 add 100+28 -> SAT build 127 / wrap build -128, ovf 1.
REQ-035 Lane1 sub -128-1 -> SAT -128 / wrap 127, ovf 1; lane2 sub -5-(-128) -> 123, ovf 0 in both builds.
REQ-036 Stream 6 beats back-to-back, out_ready low 3 cycles after first result -> in_ready low same cycles, all 6 results in order, none lost or repeated, sum stable while stalled.
REQ-037 Assert rst for 1 cycle while 2 beats in flight -> out_valid 0 immediately, sum 0, ovf_sticky 0, no stale beat after release; next beat emerges after LAT cycles.
REQ-038 Lane3 overflow transfer sets ovf_sticky[3]; clr_sticky with no overflow -> 0; clr_sticky coincident with new lane3 overflow transfer -> stays 1.
REQ-039 Random signed operands, random sub, random in_valid/out_ready over 1000 beats -> scoreboard match against exact model for the compiled build.
